// File: rtl/digit_serial_addsub_pkg.sv
// rtl/digit_serial_addsub_pkg.sv - shared FSM encoding and counter-width helper for digit_serial_addsub
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-digit operation still needs a one-bit counter to keep the logic uniform.
  function automatic int CNT_W(input int n, input int d);
    int w;
    w = $clog2(n / d);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fulladderNb.sv
// rtl/fulladderNb.sv - N-bit ripple full adder used as the digit slice
module fulladderNb #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign s    = sum[N-1:0];
  assign cout = sum[N];

endmodule

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial add/subtract unit, D bits per clock over N-bit operands
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int CW   = CNT_W(N, D);
  localparam int LAST = N / D - 1;

  if ((D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_params
    $error("digit_serial_addsub: N must be a multiple of D and 1 <= D <= N");
  end

  state_t        state_q;
  logic [N-1:0]  a_q, b_q, s_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, a_msb_q, b_msb_q;
  logic          busy_q, done_q, cout_q, ovf_q;

  logic [D-1:0]  digit_sum;
  logic          digit_cout;
  logic [N-1:0]  b_eff_d, s_d;
  logic          ovf_d, accept_d, last_d;

  fulladderNb #(.N(D)) u_digit (
    .a    (a_q[D-1:0]),
    .b    (b_q[D-1:0]),
    .cin  (carry_q),
    .s    (digit_sum),
    .cout (digit_cout)
  );

  // Subtraction inverts B and the borrow once here; the digit loop only ever adds.
  assign b_eff_d  = sub ? ~b : b;
  assign accept_d = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_d   = (cnt_q == CW'(LAST));
  assign s_d      = N'({digit_sum, s_q} >> D);
  assign ovf_d    = (a_msb_q == b_msb_q) && (s_d[N-1] != a_msb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept_d) begin
        a_q     <= a;
        b_q     <= b_eff_d;
        carry_q <= cin ^ sub;
        cnt_q   <= '0;
        a_msb_q <= a[N-1];
        b_msb_q <= b_eff_d[N-1];
      end
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> D;
          b_q     <= b_q >> D;
          s_q     <= s_d;
          carry_q <= digit_cout;
          if (last_d) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= digit_cout;
            ovf_q   <= ovf_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - directed and exhaustive checks of digit_serial_addsub
module tb_digit_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
  logic [3:0] a1, b1, s1;
  logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, s4;

  int tests_run = 0;
  int tests_failed = 0;

  digit_serial_addsub #(.N(8), .D(2)) u_dut (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

  digit_serial_addsub #(.N(4), .D(1)) u_d41 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));

  digit_serial_addsub #(.N(4), .D(4)) u_d44 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));

  // Reference for 4-bit ops: {s, cout, ovf} from integer arithmetic.
  function automatic logic [5:0] model4(input int sb, input int av, input int bv, input int c);
    int u, sr, sa, sbv;
    logic co;
    sa  = (av > 7) ? av - 16 : av;
    sbv = (bv > 7) ? bv - 16 : bv;
    if (sb == 0) begin
      u  = av + bv + c;
      co = (u > 15);
      sr = sa + sbv + c;
    end else begin
      u  = av - bv - c;
      co = (av >= bv + c);
      sr = sa - sbv - c;
    end
    return {u[3:0], co, (sr > 7) || (sr < -8)};
  endfunction

  task automatic run8(input logic sb, input logic [7:0] av, input logic [7:0] bv,
                      input logic c, output int lat, output int bcnt);
    @(negedge clk);
    start8 = 1'b1; sub8 = sb; a8 = av; b8 = bv; cin8 = c;
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) lat = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; sub1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               busy8, done8, s8, cout8, ovf8);
    end
    tests_run++;
    if ({busy1, done1, s1, cout1, ovf1, busy4, done4, s4, cout4, ovf4} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_small_outputs got s1=%h s4=%h busy1=%b busy4=%b want 0", s1, s4, busy1, busy4);
    end
  endtask

  task automatic test_add();
    int lat, bc;
    run8(1'b0, 8'h3C, 8'h15, 1'b0, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h51, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_3c_15 got s=%h c=%b v=%b want 51 0 0", s8, cout8, ovf8);
    end
    tests_run++;
    if (lat != 5) begin tests_failed++; $display("FAIL add_latency got %0d want 5", lat); end
    tests_run++;
    if (bc != 4) begin tests_failed++; $display("FAIL add_busy_cycles got %0d want 4", bc); end
    run8(1'b0, 8'hFF, 8'h01, 1'b0, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0} || lat != 5) begin
      tests_failed++;
      $display("FAIL add_ff_01 got s=%h c=%b v=%b lat=%0d want 00 1 0 5", s8, cout8, ovf8, lat);
    end
    run8(1'b0, 8'h7F, 8'h01, 1'b0, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_7f_01 got s=%h c=%b v=%b want 80 0 1", s8, cout8, ovf8);
    end
    run8(1'b0, 8'h3C, 8'h15, 1'b1, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h52, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL add_cin got s=%h c=%b v=%b want 52 0 0", s8, cout8, ovf8);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    run8(1'b1, 8'h10, 8'h20, 1'b0, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub_10_20 got s=%h c=%b v=%b want f0 0 0", s8, cout8, ovf8);
    end
    run8(1'b1, 8'h80, 8'h01, 1'b0, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub_80_01 got s=%h c=%b v=%b want 7f 1 1", s8, cout8, ovf8);
    end
    run8(1'b1, 8'h50, 8'h20, 1'b1, lat, bc);
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h2F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub_borrow_in got s=%h c=%b v=%b want 2f 1 0", s8, cout8, ovf8);
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h15; cin8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      start8 = (k == 2);
      if (k == 2) begin sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
      if (done8) lat = k;
    end
    tests_run++;
    if ({s8, cout8, ovf8} !== {8'h51, 1'b0, 1'b0} || lat != 5) begin
      tests_failed++;
      $display("FAIL start_in_run got s=%h c=%b v=%b lat=%0d want 51 0 0 5", s8, cout8, ovf8, lat);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_in_run_idle got busy=%b want 0", busy8);
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    logic overlap;
    overlap = 1'b0;
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      a8 = 8'h40; b8 = 8'h05;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) lat = k;
    end
    tests_run++;
    if (s8 !== 8'h33 || lat != 5) begin
      tests_failed++;
      $display("FAIL b2b_first got s=%h lat=%0d want 33 5", s8, lat);
    end
    lat2 = 0;
    for (int k = 1; k <= 20 && lat2 == 0; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8 && done8) overlap = 1'b1;
      if (done8) lat2 = k;
    end
    tests_run++;
    if (s8 !== 8'h45 || lat2 != 5) begin
      tests_failed++;
      $display("FAIL b2b_second got s=%h lat=%0d want 45 5", s8, lat2);
    end
    tests_run++;
    if (overlap !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_done_overlap got 1 want 0");
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, seen;
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h3C; b8 = 8'h15; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
      tests_failed++;
      $display("FAIL rst_mid_run got busy=%b done=%b s=%h c=%b v=%b want all 0",
               busy8, done8, s8, cout8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL rst_no_done got %0d active cycles want 0", seen);
    end
    run8(1'b0, 8'h01, 8'h01, 1'b0, lat, bc);
    tests_run++;
    if (s8 !== 8'h02 || lat != 5) begin
      tests_failed++;
      $display("FAIL rst_then_add got s=%h lat=%0d want 02 5", s8, lat);
    end
  endtask

  task automatic test_sweep_n4_d1();
    int lat;
    logic [5:0] exp;
    for (int sb = 0; sb < 2; sb++)
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            start1 = 1'b1; sub1 = sb[0]; a1 = av[3:0]; b1 = bv[3:0]; cin1 = c[0];
            lat = 0;
            for (int k = 1; k <= 12 && lat == 0; k++) begin
              @(negedge clk);
              start1 = 1'b0;
              if (done1) lat = k;
            end
            exp = model4(sb, av, bv, c);
            tests_run++;
            if ({s1, cout1, ovf1} !== exp || lat != 5) begin
              tests_failed++;
              $display("FAIL sweep_n4d1 sub=%0d a=%h b=%h cin=%0d got s=%h c=%b v=%b lat=%0d want s=%h c=%b v=%b lat=5",
                       sb, av, bv, c, s1, cout1, ovf1, lat, exp[5:2], exp[1], exp[0]);
            end
          end
  endtask

  task automatic test_sweep_n4_d4();
    int lat;
    logic [5:0] exp;
    for (int sb = 0; sb < 2; sb++)
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            start4 = 1'b1; sub4 = sb[0]; a4 = av[3:0]; b4 = bv[3:0]; cin4 = c[0];
            lat = 0;
            for (int k = 1; k <= 12 && lat == 0; k++) begin
              @(negedge clk);
              start4 = 1'b0;
              if (done4) lat = k;
            end
            exp = model4(sb, av, bv, c);
            tests_run++;
            if ({s4, cout4, ovf4} !== exp || lat != 2) begin
              tests_failed++;
              $display("FAIL sweep_n4d4 sub=%0d a=%h b=%h cin=%0d got s=%h c=%b v=%b lat=%0d want s=%h c=%b v=%b lat=2",
                       sb, av, bv, c, s4, cout4, ovf4, lat, exp[5:2], exp[1], exp[0]);
            end
          end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_n4_d1();
    test_sweep_n4_d4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
